ram_burst_writer: RTL and testbench
===================================

Name: ram_burst_writer

Overview:
- Write-side counterpart to the team's 8x16 single-address ROM: an 8x16 RAM loaded by a handshaked burst-write engine.
- The engine accepts a start command (base address, length) and then a valid/ready word stream, writing consecutive addresses with wrap-around.
- An independent registered read port lets consumers read contents back with the same 1-cycle latency as the ROM.

Parameters:
- DATA_WIDTH, 16, word width
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH = 8

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  burst request, sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first write address
- burst_len  in  ADDR_WIDTH+1  words in burst, legal 1..DEPTH
- wr_valid  in  1  wr_data valid
- wr_data  in  DATA_WIDTH  word to write
- wr_ready  out  1  engine accepts a word this cycle
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after last word written
- err  out  1  one-cycle pulse on illegal start
- rd_en  in  1  read enable
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  registered read data

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - wr_ready=0, busy=0, done=0, err=0, rd_data=0, state=IDLE.
  - Memory array is not cleared.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - start=1 with 1<=burst_len<=DEPTH: latch addr_ptr=start_addr and remaining=burst_len, go to WRITE.
  - start=1 with burst_len==0 or burst_len>DEPTH: err=1 for one cycle, stay IDLE, memory untouched.
  - start=0: stay IDLE.
- WRITE:
  - wr_ready=1 and busy=1.
  - A transfer occurs on a cycle where wr_valid and wr_ready are both high. On each transfer: mem[addr_ptr] <= wr_data, addr_ptr <= addr_ptr+1 mod DEPTH (7 wraps to 0), remaining <= remaining-1.
  - wr_valid low: stall with no write and no pointer change; there is no timeout.
  - Transfer with remaining==1: go to DONE.
- DONE:
  - wr_ready=0, busy=0, done=1 for exactly one cycle.
  - Unconditionally return to IDLE next cycle.
  - A start seen during DONE is ignored.
- Busy and ready timing:
  - busy is 1 only in WRITE.
  - wr_ready is combinationally equal to (state==WRITE).
- start asserted while in WRITE or DONE is ignored, with no err.
- Back-to-back bursts: the earliest next accepted start is the cycle after done.
- Read port:
  - rd_en=1: rd_data <= mem[rd_addr] at the next edge (1-cycle latency).
  - rd_en=0: rd_data holds its previous value.
- Read/write collision on the same address in the same cycle: read-before-write, so rd_data returns the old word and the new word is visible on the next read.
- Reset mid-burst aborts: the FSM returns to IDLE and words already written stay in memory.
- burst_len==DEPTH writes every location exactly once, ending at start_addr-1 mod DEPTH.

Decomposition:
- Shared package ram_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, DEPTH constants
  - the wr_state_t enum {IDLE, WRITE, DONE}
  - the word_t and addr_t typedefs
- Sub-module ram_core_sp (1W/1R synchronous array) contains:
  - the write port: we, waddr, wdata
  - the registered read port: re, raddr, rdata, with read-before-write
- ram_burst_writer holds the FSM, address pointer and counter, and instantiates ram_core_sp.

Test Plan:
- Basic burst: start_addr=2, burst_len=3, wr_valid held high, data 16'h1111/2222/3333.
  - Required: wr_ready high for 3 cycles, done pulses once the cycle after the third transfer.
  - Reads of addresses 2,3,4 return 1111, 2222, 3333, each 1 cycle after rd_en.
- Wrap-around: start_addr=6, burst_len=4, data A0A0/B1B1/C2C2/D3D3.
  - Required: mem[6]=A0A0, mem[7]=B1B1, mem[0]=C2C2, mem[1]=D3D3; mem[2] unchanged.
- Stall and ignored start: burst_len=2 with wr_valid low for 5 cycles between words, and start pulsed mid-burst.
  - Required: busy stays high and exactly 2 writes occur.
  - The mid-burst start causes no err and no new burst.
- Illegal length: start with burst_len=0, then with burst_len=9.
  - Required: err pulses 1 cycle each time, busy stays 0, and a memory readback is unchanged.
- Collision: mem[5]=5555, a burst writes 16'hAAAA to address 5 while rd_en=1 and rd_addr=5 in the same cycle.
  - Required: rd_data=5555 on that read; a read the following cycle returns AAAA.
- Reset mid-burst: burst_len=8 from addr 0, rst_n low after 3 transfers.
  - Required next cycle: busy=0, wr_ready=0, done=0, rd_data=0.
  - Addresses 0..2 hold the written words; a new start is accepted afterwards.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and types for the 8x16 burst-written RAM slice.
package ram_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/ram_core_sp.sv
// Single-clock 1W/1R array with a registered, read-before-write read port.
module ram_core_sp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Write port; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read; a same-cycle write to raddr is seen only on the next read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/ram_burst_writer.sv
// Burst-write engine: accepts (start_addr, burst_len), then streams valid/ready
// words into consecutive RAM addresses with wrap-around.
module ram_burst_writer
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   burst_len,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

    wr_state_t             state_r;
    logic [ADDR_WIDTH-1:0] addr_ptr_r;
    logic [ADDR_WIDTH:0]   remaining_r;
    logic                  err_r;
    logic                  len_ok_s;
    logic                  xfer_s;

    assign len_ok_s = (burst_len != {(ADDR_WIDTH+1){1'b0}}) && (burst_len <= DEPTH_L);
    assign xfer_s   = (state_r == WRITE) && wr_valid;

    // Burst FSM with address pointer, word counter and error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            addr_ptr_r  <= {ADDR_WIDTH{1'b0}};
            remaining_r <= {(ADDR_WIDTH+1){1'b0}};
            err_r       <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && len_ok_s) begin
                        addr_ptr_r  <= start_addr;
                        remaining_r <= burst_len;
                        state_r     <= WRITE;
                    end else if (start) begin
                        err_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        // Natural overflow of the pointer gives the wrap 7 -> 0.
                        addr_ptr_r  <= addr_ptr_r + ADDR_WIDTH'(1);
                        remaining_r <= remaining_r - ONE_L;
                        if (remaining_r == ONE_L) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= WRITE;
                        end
                    end else begin
                        state_r <= WRITE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign wr_ready = (state_r == WRITE);
    assign busy     = (state_r == WRITE);
    assign done     = (state_r == DONE);
    assign err      = err_r;

    ram_core_sp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (xfer_s),
        .waddr (addr_ptr_r),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_ram_burst_writer.sv
// Directed bench for ram_burst_writer; read data is checked by a scoreboard monitor.
module tb_ram_burst_writer;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   burst_len;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int wr_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic rd_pend = 1'b0;

    always #5 clk = ~clk;

    ram_burst_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .burst_len  (burst_len),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Edge-side bookkeeping: which cycles carried a read or a transfer.
    always @(posedge clk) begin
        rd_pend <= rd_en;
        if (rst_n && wr_valid && wr_ready) wr_cnt++;
    end

    // Monitor: count pulses and compare read data against the scoreboard.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (wr_ready) ready_cnt++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (rd_pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = a; exp_q.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic send_start(input logic [AW-1:0] a, input logic [AW:0] l);
        @(negedge clk);
        start = 1'b1; start_addr = a; burst_len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        int n = 0;
        while (!wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            chk("ready_timeout", 32'(wr_ready), 32'd1);
        end else begin
            wr_valid = 1'b1; wr_data = d;
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    initial begin
        int rc, dc, ec, wc, n;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; burst_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;

        // Basic burst at 2..4.
        rc = ready_cnt; dc = done_cnt;
        send_start(3'd2, 4'd3);
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("basic_done_count", 32'(done_cnt - dc), 32'd1);
        chk("basic_ready_cycles", 32'(ready_cnt - rc), 32'd3);
        rd(3'd2, 16'h1111);
        rd(3'd3, 16'h2222);
        rd(3'd4, 16'h3333);

        // Wrap-around 6,7,0,1; address 2 keeps its word.
        send_start(3'd6, 4'd4);
        send_word(16'hA0A0);
        send_word(16'hB1B1);
        send_word(16'hC2C2);
        send_word(16'hD3D3);
        @(negedge clk);
        rd(3'd6, 16'hA0A0);
        rd(3'd7, 16'hB1B1);
        rd(3'd0, 16'hC2C2);
        rd(3'd1, 16'hD3D3);
        rd(3'd2, 16'h1111);

        // Stalled two-word burst with a start pulsed in the gap.
        ec = err_cnt; wc = wr_cnt; dc = done_cnt;
        send_start(3'd3, 4'd2);
        send_word(16'h3A3A);
        for (int i = 0; i < 5; i++) begin
            chk("stall_busy", 32'(busy), 32'd1);
            if (i == 2) begin
                start = 1'b1; start_addr = 3'd7; burst_len = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        send_word(16'h4B4B);
        chk("stall_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        chk("stall_no_new_burst", 32'(busy), 32'd0);
        chk("stall_no_err", 32'(err_cnt - ec), 32'd0);
        chk("stall_writes", 32'(wr_cnt - wc), 32'd2);
        chk("stall_done_count", 32'(done_cnt - dc), 32'd1);
        rd(3'd3, 16'h3A3A);
        rd(3'd4, 16'h4B4B);
        rd(3'd2, 16'h1111);

        // Illegal lengths 0 and 9.
        ec = err_cnt; wc = wr_cnt;
        send_start(3'd0, 4'd0);
        chk("illegal0_err", 32'(err), 32'd1);
        chk("illegal0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("illegal0_err_drop", 32'(err), 32'd0);
        send_start(3'd1, 4'd9);
        chk("illegal9_err", 32'(err), 32'd1);
        chk("illegal9_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("illegal_err_count", 32'(err_cnt - ec), 32'd2);
        chk("illegal_no_writes", 32'(wr_cnt - wc), 32'd0);
        rd(3'd0, 16'hC2C2);
        rd(3'd1, 16'hD3D3);

        // Read/write collision on address 5.
        send_start(3'd5, 4'd1);
        send_word(16'h5555);
        @(negedge clk);
        send_start(3'd5, 4'd1);
        chk("coll_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1; wr_data = 16'hAAAA;
        rd_en = 1'b1; rd_addr = 3'd5; exp_q.push_back(16'h5555);
        @(negedge clk);
        wr_valid = 1'b0; exp_q.push_back(16'hAAAA);
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);

        // Reset three words into an eight-word burst.
        dc = done_cnt;
        send_start(3'd0, 4'd8);
        send_word(16'h0101);
        send_word(16'h0202);
        send_word(16'h0303);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wr_ready", 32'(wr_ready), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
        rd(3'd0, 16'h0101);
        rd(3'd1, 16'h0202);
        rd(3'd2, 16'h0303);
        send_start(3'd6, 4'd1);
        chk("restart_busy", 32'(busy), 32'd1);
        send_word(16'h6666);
        chk("restart_done", 32'(done), 32'd1);
        rd(3'd6, 16'h6666);
        rd(3'd7, 16'hB1B1);

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
